// File: rtl/game_pkg.sv
// Shared game geometry and state encoding, imported by traffic_ctrl, car_mover and vga
// so drawing and collision always use the same box sizes.
package game_pkg;

  localparam int SCREEN_W      = 640;
  localparam int SCREEN_H      = 480;
  localparam int CAR_WIDTH     = 32;
  localparam int CAR_HEIGHT    = 16;
  localparam int PLAYER_WIDTH  = 16;
  localparam int PLAYER_HEIGHT = 16;
  localparam int LANE_Y_1      = 96;
  localparam int LANE_Y_2      = 192;
  localparam int LANE_Y_3      = 288;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HIT  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  // Strict 1-D overlap of [a_pos, a_pos+a_len) and [b_pos, b_pos+b_len); touching edges miss.
  function automatic logic span_overlap(input logic [10:0] a_pos, input logic [10:0] a_len,
                                        input logic [10:0] b_pos, input logic [10:0] b_len);
    return (a_pos < b_pos + b_len) && (b_pos < a_pos + a_len);
  endfunction

endpackage

// File: rtl/car_mover.sv
// One car's X register: steps by SPEED once per frame in a fixed direction and wraps
// at the screen edges; load restores the start position.
module car_mover
  import game_pkg::*;
#(
  parameter bit MOVE_RIGHT = 1'b1,
  parameter int SPEED      = 2,
  parameter int START_X    = 0,
  parameter int WRAP_W     = game_pkg::SCREEN_W,
  parameter int CAR_W      = game_pkg::CAR_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       load,
  output logic [9:0] x
);

  localparam logic [10:0] SPD       = 11'(SPEED);
  localparam logic [10:0] RIGHT_LIM = 11'(WRAP_W);
  localparam logic [10:0] LEFT_WRAP = 11'(WRAP_W - CAR_W);
  localparam logic [9:0]  START_POS = 10'(START_X);

  logic [9:0]  x_reg;
  logic [10:0] x_wide;
  logic [10:0] sum_right;
  logic [10:0] x_next;

  always_comb begin
    x_wide    = {1'b0, x_reg};
    sum_right = x_wide + SPD;
    x_next    = x_wide;
    if (MOVE_RIGHT) begin
      x_next = (sum_right >= RIGHT_LIM) ? 11'd0 : sum_right;
    end else begin
      x_next = (x_wide < SPD) ? LEFT_WRAP : (x_wide - SPD);
    end
  end

  // Positions stay below WRAP_W, so the top bit of x_next is always zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg <= START_POS;
    end else if (load) begin
      x_reg <= START_POS;
    end else if (step) begin
      x_reg <= x_next[9:0];
    end
  end

  assign x = x_reg;

endmodule

// File: rtl/traffic_ctrl.sv
// Per-frame car motion, raccoon/car collision, lives and game-over tracking.
// Define TRAFFIC_INVINCIBILITY_EN to enable the post-hit invincibility (HIT) window.
module traffic_ctrl
  import game_pkg::*;
#(
  parameter int SCREEN_W      = game_pkg::SCREEN_W,
  parameter int CAR_WIDTH     = game_pkg::CAR_WIDTH,
  parameter int CAR_HEIGHT    = game_pkg::CAR_HEIGHT,
  parameter int PLAYER_WIDTH  = game_pkg::PLAYER_WIDTH,
  parameter int PLAYER_HEIGHT = game_pkg::PLAYER_HEIGHT,
  parameter int LANE_Y_1      = game_pkg::LANE_Y_1,
  parameter int LANE_Y_2      = game_pkg::LANE_Y_2,
  parameter int LANE_Y_3      = game_pkg::LANE_Y_3,
  parameter int START_X_1     = 0,
  parameter int START_X_2     = 320,
  parameter int START_X_3     = 160,
  parameter int SPEED_1       = 2,
  parameter int SPEED_2       = 3,
  parameter int SPEED_3       = 4,
  parameter int START_LIVES   = 3,
  parameter int HIT_FRAMES    = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       restart,
  input  logic [9:0] raccoonX,
  input  logic [9:0] raccoonY,
  output logic [9:0] carX_1,
  output logic [9:0] carX_2,
  output logic [9:0] carX_3,
  output logic [9:0] carY_1,
  output logic [9:0] carY_2,
  output logic [9:0] carY_3,
  output logic [2:0] lives,
  output logic       hit,
  output logic       game_over
);

  localparam logic [2:0][3:0] SPEED_VEC = {4'(SPEED_3), 4'(SPEED_2), 4'(SPEED_1)};
  localparam logic [2:0][9:0] START_VEC = {10'(START_X_3), 10'(START_X_2), 10'(START_X_1)};
  localparam logic [2:0][9:0] LANE_VEC  = {10'(LANE_Y_3), 10'(LANE_Y_2), 10'(LANE_Y_1)};
  localparam logic [2:0]      LIVES_INIT = 3'(START_LIVES);

  state_t     state_reg, state_next;
  logic [2:0] lives_reg, lives_next;
  logic       hit_reg, hit_next;
`ifdef TRAFFIC_INVINCIBILITY_EN
  localparam logic [7:0] HIT_LOAD = 8'(HIT_FRAMES);
  logic [7:0] cool_reg, cool_next;
`endif

  logic [2:0][9:0] car_x;
  logic [2:0]      coll_car;
  logic            coll;
  logic            step;

  // OVER freezes the cars; restart overrides a same-cycle tick.
  assign step = frame_tick && !restart && (state_reg != ST_OVER);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_car
      car_mover #(
        .MOVE_RIGHT(gi != 1),
        .SPEED     (int'(SPEED_VEC[gi])),
        .START_X   (int'(START_VEC[gi])),
        .WRAP_W    (SCREEN_W),
        .CAR_W     (CAR_WIDTH)
      ) u_car (
        .clk (clk),
        .rst (rst),
        .step(step),
        .load(restart),
        .x   (car_x[gi])
      );

      // Uses the registered (pre-move) car position current on the tick cycle.
      assign coll_car[gi] =
        span_overlap({1'b0, raccoonX}, 11'(PLAYER_WIDTH), {1'b0, car_x[gi]}, 11'(CAR_WIDTH)) &&
        span_overlap({1'b0, raccoonY}, 11'(PLAYER_HEIGHT), {1'b0, LANE_VEC[gi]}, 11'(CAR_HEIGHT));
    end
  endgenerate

  assign coll = |coll_car;

  always_comb begin
    state_next = state_reg;
    lives_next = lives_reg;
    hit_next   = 1'b0;
`ifdef TRAFFIC_INVINCIBILITY_EN
    cool_next  = cool_reg;
`endif
    if (restart) begin
      state_next = ST_PLAY;
      lives_next = LIVES_INIT;
`ifdef TRAFFIC_INVINCIBILITY_EN
      cool_next  = 8'd0;
`endif
    end else if (frame_tick) begin
      case (state_reg)
        ST_PLAY: begin
          if (coll) begin
            hit_next = 1'b1;
            if (lives_reg > 3'd1) begin
              lives_next = lives_reg - 3'd1;
`ifdef TRAFFIC_INVINCIBILITY_EN
              state_next = ST_HIT;
              cool_next  = HIT_LOAD;
`endif
            end else begin
              lives_next = 3'd0;
              state_next = ST_OVER;
            end
          end
        end
        ST_HIT: begin
`ifdef TRAFFIC_INVINCIBILITY_EN
          if (cool_reg <= 8'd1) begin
            state_next = ST_PLAY;
            cool_next  = 8'd0;
          end else begin
            cool_next = cool_reg - 8'd1;
          end
`else
          state_next = ST_PLAY;
`endif
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_PLAY;
      lives_reg <= LIVES_INIT;
      hit_reg   <= 1'b0;
`ifdef TRAFFIC_INVINCIBILITY_EN
      cool_reg  <= 8'd0;
`endif
    end else begin
      state_reg <= state_next;
      lives_reg <= lives_next;
      hit_reg   <= hit_next;
`ifdef TRAFFIC_INVINCIBILITY_EN
      cool_reg  <= cool_next;
`endif
    end
  end

  assign carX_1    = car_x[0];
  assign carX_2    = car_x[1];
  assign carX_3    = car_x[2];
  assign carY_1    = LANE_VEC[0];
  assign carY_2    = LANE_VEC[1];
  assign carY_3    = LANE_VEC[2];
  assign lives     = lives_reg;
  assign hit       = hit_reg;
  assign game_over = (state_reg == ST_OVER);

endmodule

// File: tb/tb_traffic_ctrl.sv
// Self-checking bench for traffic_ctrl: frame-level game model compared every cycle,
// plus directed literal checks of wrap, edge-touch, invincibility, game over, restart and reset.
module tb_traffic_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       restart = 1'b0;
  logic [9:0] raccoonX = 10'd600;
  logic [9:0] raccoonY = 10'd450;
  logic [9:0] carX_1, carX_2, carX_3, carY_1, carY_2, carY_3;
  logic [2:0] lives;
  logic       hit, game_over;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  traffic_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .restart   (restart),
    .raccoonX  (raccoonX),
    .raccoonY  (raccoonY),
    .carX_1    (carX_1),
    .carX_2    (carX_2),
    .carX_3    (carX_3),
    .carY_1    (carY_1),
    .carY_2    (carY_2),
    .carY_3    (carY_3),
    .lives     (lives),
    .hit       (hit),
    .game_over (game_over)
  );

  // ---------------- frame-level game model ----------------
  int start_x [3] = '{0, 320, 160};
  int speed   [3] = '{2, 3, 4};
  int dirn    [3] = '{1, -1, 1};
  int lane_y  [3] = '{96, 192, 288};

  int m_x [3] = '{0, 320, 160};
  int m_lives = 3;
  int m_hit   = 0;
  int m_over  = 0;
  int m_inv   = 0;   // frames of invincibility left

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_x[i] = start_x[i];
    m_lives = 3;
    m_hit   = 0;
    m_over  = 0;
    m_inv   = 0;
  endtask

  always @(posedge clk or posedge rst) begin : model
    int touching;
    int p;
    if (rst || restart) begin
      model_reset();
    end else begin
      m_hit = 0;
      if (frame_tick && m_over == 0) begin
        touching = 0;
        for (int i = 0; i < 3; i++) begin
          if (int'(raccoonX) < m_x[i] + 32 && m_x[i] < int'(raccoonX) + 16 &&
              int'(raccoonY) < lane_y[i] + 16 && lane_y[i] < int'(raccoonY) + 16)
            touching = 1;
        end
        for (int i = 0; i < 3; i++) begin
          p = m_x[i] + dirn[i] * speed[i];
          if (p >= 640) p = 0;
          else if (p < 0) p = 640 - 32;
          m_x[i] = p;
        end
        if (m_inv > 0) begin
          m_inv = m_inv - 1;
        end else if (touching != 0) begin
          m_hit   = 1;
          m_lives = m_lives - 1;
          if (m_lives == 0) m_over = 1;
`ifdef TRAFFIC_INVINCIBILITY_EN
          else m_inv = 60;
`endif
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: every cycle, all outputs against the model.
  always @(negedge clk) begin
    chk("cmp_carX_1", {22'd0, carX_1}, m_x[0]);
    chk("cmp_carX_2", {22'd0, carX_2}, m_x[1]);
    chk("cmp_carX_3", {22'd0, carX_3}, m_x[2]);
    chk("cmp_carY_1", {22'd0, carY_1}, lane_y[0]);
    chk("cmp_carY_2", {22'd0, carY_2}, lane_y[1]);
    chk("cmp_carY_3", {22'd0, carY_3}, lane_y[2]);
    chk("cmp_lives", {29'd0, lives}, m_lives);
    chk("cmp_hit", {31'd0, hit}, m_hit);
    chk("cmp_game_over", {31'd0, game_over}, m_over);
  end

  task automatic tick(input int rx, input int ry);
    @(negedge clk);
    raccoonX   = 10'(rx);
    raccoonY   = 10'(ry);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    $display("tick raccoon=(%0d,%0d) cars=%0d/%0d/%0d lives=%0d hit=%0b over=%0b",
             rx, ry, carX_1, carX_2, carX_3, lives, hit, game_over);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int sx1, sx2, sx3;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_carX_1", {22'd0, carX_1}, 0);
    chk("rst_carX_2", {22'd0, carX_2}, 320);
    chk("rst_carX_3", {22'd0, carX_3}, 160);
    chk("rst_carY_2", {22'd0, carY_2}, 192);
    chk("rst_lives", {29'd0, lives}, 3);
    chk("rst_go", {31'd0, game_over}, 0);

    // ten frames with the raccoon out of every lane
    for (int k = 0; k < 10; k++) tick(600, 450);
    chk("t10_carX_1", {22'd0, carX_1}, 20);
    chk("t10_carX_2", {22'd0, carX_2}, 290);
    chk("t10_carX_3", {22'd0, carX_3}, 200);
    chk("t10_lives", {29'd0, lives}, 3);

    // car 2 left wrap from X=2
    for (int k = 0; k < 400 && m_x[1] != 2; k++) tick(600, 450);
    chk("pre_wrap_carX_2", {22'd0, carX_2}, 2);
    tick(600, 450);
    chk("wrap_carX_2", {22'd0, carX_2}, 608);

    // car 1 right wrap from X=638
    for (int k = 0; k < 400 && m_x[0] != 638; k++) tick(600, 450);
    chk("pre_wrap_carX_1", {22'd0, carX_1}, 638);
    tick(600, 450);
    chk("wrap_carX_1", {22'd0, carX_1}, 0);

    // touching edge only, then one-pixel overlap
    tick(m_x[0] + 32, 96);
    chk("edge_hit", {31'd0, hit}, 0);
    chk("edge_lives", {29'd0, lives}, 3);
    tick(m_x[0] + 31, 96);
    chk("overlap_hit", {31'd0, hit}, 1);
    chk("overlap_lives", {29'd0, lives}, 2);
    @(negedge clk);
    chk("hit_one_cycle", {31'd0, hit}, 0);

`ifdef TRAFFIC_INVINCIBILITY_EN
    for (int k = 0; k < 60; k++) begin
      tick(m_x[0] + 31, 96);
      chk("inv_lives", {29'd0, lives}, 2);
    end
    tick(m_x[0] + 31, 96);
    chk("post_inv_lives", {29'd0, lives}, 1);
    chk("post_inv_hit", {31'd0, hit}, 1);
    for (int k = 0; k < 60; k++) tick(600, 450);
`else
    tick(m_x[0] + 31, 96);
    chk("second_hit_lives", {29'd0, lives}, 1);
    chk("second_hit_hit", {31'd0, hit}, 1);
`endif

    // final hit
    tick(m_x[0] + 31, 96);
    chk("final_lives", {29'd0, lives}, 0);
    chk("final_go", {31'd0, game_over}, 1);
    chk("final_hit", {31'd0, hit}, 1);
    sx1 = m_x[0]; sx2 = m_x[1]; sx3 = m_x[2];
    for (int k = 0; k < 5; k++) tick(m_x[0] + 31, 96);
    chk("frozen_carX_1", {22'd0, carX_1}, sx1);
    chk("frozen_carX_2", {22'd0, carX_2}, sx2);
    chk("frozen_carX_3", {22'd0, carX_3}, sx3);
    chk("frozen_go", {31'd0, game_over}, 1);

    // restart together with frame_tick, raccoon overlapping car 1's start
    @(negedge clk);
    raccoonX = 10'd31; raccoonY = 10'd96;
    restart = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    restart = 1'b0; frame_tick = 1'b0;
    chk("restart_lives", {29'd0, lives}, 3);
    chk("restart_carX_1", {22'd0, carX_1}, 0);
    chk("restart_carX_2", {22'd0, carX_2}, 320);
    chk("restart_carX_3", {22'd0, carX_3}, 160);
    chk("restart_go", {31'd0, game_over}, 0);
    chk("restart_hit", {31'd0, hit}, 0);

    // hit, run partway through the cooldown, then async reset
    for (int k = 0; k < 5; k++) tick(600, 450);
    tick(m_x[0] + 31, 96);
    chk("pre_rst_lives", {29'd0, lives}, 2);
`ifdef TRAFFIC_INVINCIBILITY_EN
    for (int k = 0; k < 30; k++) tick(600, 450);
`else
    tick(600, 450);
`endif
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_carX_1", {22'd0, carX_1}, 0);
    chk("async_rst_carX_2", {22'd0, carX_2}, 320);
    chk("async_rst_lives", {29'd0, lives}, 3);
    chk("async_rst_hit", {31'd0, hit}, 0);

    // frame_tick during reset is ignored
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("tick_in_rst_carX_1", {22'd0, carX_1}, 0);
    rst = 1'b0;
    tick(600, 450);
    chk("after_rst_carX_1", {22'd0, carX_1}, 2);
    chk("after_rst_carX_2", {22'd0, carX_2}, 317);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl.md
# traffic_ctrl

Game-state stage directly upstream of the `vga` renderer. It advances three cars along fixed lanes once per video frame and detects raccoon/car collisions. It also maintains the lives counter, with a post-hit invincibility window and a game-over state. All car positions and `lives` feed `vga` unchanged; raccoon position comes from the player-input stage.

## Interface
Parameters:
- `SCREEN_W`, 640: active width in pixels.
- `CAR_WIDTH`, 32 / `CAR_HEIGHT`, 16: car box size.
- `PLAYER_WIDTH`, 16 / `PLAYER_HEIGHT`, 16: raccoon box size.
- `LANE_Y_1`, `LANE_Y_2`, `LANE_Y_3`, 96 / 192 / 288: fixed car Y per lane.
- `START_X_1`, `START_X_2`, `START_X_3`, 0 / 320 / 160: car X after reset or restart.
- `SPEED_1`, `SPEED_2`, `SPEED_3`, 2 / 3 / 4: pixels per frame, each 1..15.
- `START_LIVES`, 3: lives after reset or restart, 1..7.
- `HIT_FRAMES`, 60: invincibility length in frames, 1..255.

Ports:
- `clk`  in  1  system clock (pixel clock domain)
- `rst`  in  1  reset; **asynchronous, active-high**
- `frame_tick`  in  1  one-cycle pulse per frame, issued at start of vertical blanking
- `restart`  in  1  one-cycle pulse requesting a new game
- `raccoonX`, `raccoonY`  in  10 each  raccoon top-left corner
- `carX_1`..`carX_3`  out  10 each  car top-left X
- `carY_1`..`carY_3`  out  10 each  car top-left Y
- `lives`  out  3  remaining lives
- `hit`  out  1  one-cycle pulse when a life is lost
- `game_over`  out  1  high while in OVER

## Operation
- Reset values:
  - `carX_n` = `START_X_n`; `carY_n` = `LANE_Y_n`, constant at all times.
  - `lives` = `START_LIVES`; `hit` = 0; `game_over` = 0.
  - State = PLAY; cooldown = 0.
- Direction: cars 1 and 3 move right (+X); car 2 moves left (-X).
- Motion wrap, with all arithmetic in 11 bits:
  - Rightward: if `carX + SPEED >= SCREEN_W`, next = 0; else next = `carX + SPEED`.
  - Leftward: if `carX < SPEED`, next = `SCREEN_W - CAR_WIDTH`; else next = `carX - SPEED`.
- Collision: strict box overlap, computed in 11 bits, against the registered car positions current on the `frame_tick` cycle (pre-move values).
  - `raccoonX < carX + CAR_WIDTH` and `carX < raccoonX + PLAYER_WIDTH`.
  - Same test on Y using the height parameters.
  - `coll` = OR of the three per-car tests. Touching edges do not collide.
- State machine; state updates only on `frame_tick` or `restart`:
  - **PLAY**, on `frame_tick`:
    - Cars move.
    - If `coll` and `lives > 1`: decrement `lives`, pulse `hit`, load cooldown = `HIT_FRAMES`, go to HIT.
    - If `coll` and `lives == 1`: set `lives` = 0, pulse `hit`, go to OVER.
  - **HIT**, on `frame_tick`:
    - Cars move; `coll` is ignored.
    - Cooldown decrements; when it reaches 1 on a tick, return to PLAY (exactly `HIT_FRAMES` ticks spent in HIT).
  - **OVER**: cars frozen; `game_over` = 1; `frame_tick` ignored.
- `restart` is accepted in any state. It reloads the reset values (except the async path) and enters PLAY.

## Timing
- All outputs are registered.
- Positions, `lives`, `hit` and `game_over` change on the clock edge that samples `frame_tick`; they are visible the next cycle.
- `hit` is high for exactly one cycle.
- `restart` and `frame_tick` in the same cycle: `restart` wins; no motion and no collision check that frame.
- `frame_tick` held high for several cycles is treated as multiple frames. This is the caller's responsibility; the block does no edge detection.
- `rst` asserted mid-game: outputs return to reset values immediately (asynchronously).
- `frame_tick` while `rst` is high is ignored.
- Inputs `raccoonX`/`raccoonY` are sampled only on the tick cycle and must be stable on it.

## Configuration
- Macro `TRAFFIC_INVINCIBILITY_EN`.
- Defined: HIT behaves as specified above.
- Undefined: HIT is not implemented; a non-final collision decrements `lives`, pulses `hit` and stays in PLAY. Consecutive frames of overlap each cost a life.
- `HIT_FRAMES` and the cooldown counter are unused when the macro is undefined.

## Structure
- Shared package `game_pkg`:
  - Screen dimensions, `CAR_WIDTH`/`CAR_HEIGHT`, `PLAYER_WIDTH`/`PLAYER_HEIGHT`, lane Y constants.
  - State enum (PLAY, HIT, OVER).
  - `vga` imports the same sizes so drawing and collision always agree.
- Sub-module `car_mover`, one per car.
  - Parameters: direction, speed, start X.
  - Inputs: `clk`, `rst`, `step`, `load`. Output: 10-bit X.
  - Contains the wrap logic.
- `traffic_ctrl` holds the FSM, collision compare, lives and cooldown counters.

## Test plan
- Reset, then 10 ticks with the raccoon at (600,450): `carX_1`=20, `carX_2`=290, `carX_3`=200; `lives`=3; `hit` never asserted.
- Car 2 wrap: X=2, `SPEED_2`=3, one tick -> `carX_2`=608. Car 1 wrap: X=638, one tick -> `carX_1`=0.
- Edge case: raccoon at (`carX_1`+32, 96), touching edge only -> no hit. Raccoon at `carX_1`+31 -> `hit` pulse, `lives` 3->2, state HIT.
- Invincibility: keep overlapping for 60 ticks after a hit -> `lives` stays 2. Still overlapping on tick 61 -> `lives`=1.
- Final hit: at `lives`=1, collide -> `lives`=0, `game_over`=1, positions frozen across 5 ticks. Then `restart` together with `frame_tick` -> `lives`=3, cars at start X, `game_over`=0.
- Assert `rst` mid-HIT with cooldown 30 -> outputs at reset values before the next clock edge. With `TRAFFIC_INVINCIBILITY_EN` undefined, two consecutive overlapping ticks -> `lives` 3->1.
